sequence_detector: RTL and testbench

// - Serial bit-pattern detector: samples 1 input bit per clk rising edge and pulses out for 1 cycle

---
 rtl/seq_det_pkg.sv | 81 ++++++++
 rtl/sequence_detector.sv | 82 ++++++++
 tb/tb_sequence_detector.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared constants and elaboration-time helpers for the serial pattern
// detector.
//   DEF_PAT_LEN / DEF_PATTERN / DEF_OVERLAP : default detector configuration
//   state_width() : bits needed to hold a matched-prefix length 0..pat_len
//   kmp_fail()    : longest proper prefix of the pattern that is also a
//                   suffix of the first m pattern bits
//   kmp_next()    : matched-prefix length after appending one bit to the
//                   first m pattern bits (advance or KMP fallback)
// All functions are evaluated with constant arguments only. They build a
// fixed transition table, so none of this becomes runtime logic.
// -----------------------------------------------------------------------------
package seq_det_pkg;

    localparam int MAX_PAT_LEN = 16;
    localparam int DEF_PAT_LEN = 4;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b1011;
    localparam bit DEF_OVERLAP = 1'b1;

    function automatic int state_width(input int pat_len);
        return (pat_len < 1) ? 1 : $clog2(pat_len + 1);
    endfunction

    // Pattern bit in arrival order. Index 0 is the first bit received,
    // which is the MSB of the pattern word.
    function automatic logic pat_bit(input logic [MAX_PAT_LEN-1:0] pat,
                                     input int pat_len, input int idx);
        return pat[pat_len - 1 - idx];
    endfunction

    function automatic int kmp_fail(input logic [MAX_PAT_LEN-1:0] pat,
                                    input int pat_len, input int m);
        int  best;
        logic ok;
        best = 0;
        for (int k = 1; k <= MAX_PAT_LEN; k++) begin
            if (k < m) begin
                ok = 1'b1;
                for (int j = 0; j < MAX_PAT_LEN; j++) begin
                    if (j < k) begin
                        if (pat_bit(pat, pat_len, j) != pat_bit(pat, pat_len, m - k + j))
                            ok = 1'b0;
                    end
                end
                if (ok)
                    best = k;
            end
        end
        return best;
    endfunction

    // The candidate string is (first m pattern bits, b), which has length m+1.
    // Returns the longest k <= pat_len such that the first k pattern bits equal
    // the last k bits of that string. When k = m+1, the pattern simply advanced.
    function automatic int kmp_next(input logic [MAX_PAT_LEN-1:0] pat,
                                    input int pat_len, input int m, input logic b);
        int   best;
        int   pos;
        logic ok;
        logic sb;
        best = 0;
        for (int k = 1; k <= MAX_PAT_LEN; k++) begin
            if (k <= pat_len && k <= m + 1) begin
                ok = 1'b1;
                for (int j = 0; j < MAX_PAT_LEN; j++) begin
                    if (j < k) begin
                        pos = m + 1 - k + j;
                        sb  = (pos == m) ? b : pat_bit(pat, pat_len, pos);
                        if (sb != pat_bit(pat, pat_len, j))
                            ok = 1'b0;
                    end
                end
                if (ok)
                    best = k;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/sequence_detector.sv
// -----------------------------------------------------------------------------
// sequence_detector
// This module is a serial bit-pattern detector. It samples one bit on every
// rising clk edge. When the last PAT_LEN sampled bits equal PATTERN, it raises
// out for exactly one cycle. The first bit received is compared against the
// pattern MSB.
//
// Parameters
//   PAT_LEN  pattern length, 2..16
//   PATTERN  pattern word, MSB is received first
//   OVERLAP  1: the tail of a match may begin the next match
//            0: matching restarts from empty after each match
// Ports
//   seq_bit  in   serial data bit. The natural name 'sequence' is a reserved
//                 SystemVerilog keyword, so the port is called seq_bit.
//   clk      in   clock; all state changes happen on the rising edge
//   rstn     in   asynchronous active-low reset
//   out      out  one-cycle detect pulse, decoded from the state register
//
// state             | meaning
// ------------------+--------------------------------------------------
// S_IDLE (0)        | no pattern bits matched
// 1 .. PAT_LEN-1    | that many leading pattern bits matched so far
// S_MATCH (PAT_LEN) | full pattern matched; out is high this cycle
// -----------------------------------------------------------------------------
module sequence_detector
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter bit                 OVERLAP = DEF_OVERLAP
) (
    input  logic seq_bit,
    input  logic clk,
    input  logic rstn,
    output logic out
);

    localparam int SW = state_width(PAT_LEN);
    localparam logic [SW-1:0] S_IDLE  = '0;
    localparam logic [SW-1:0] S_MATCH = SW'(PAT_LEN);
    localparam logic [MAX_PAT_LEN-1:0] PAT_W = MAX_PAT_LEN'(PATTERN);

    // After a full match, the next bit is applied as if the detector had
    // already fallen back: to the longest self-overlapping prefix, or to
    // empty when overlapping matches are disabled.
    localparam int FULL_RESTART = OVERLAP ? kmp_fail(PAT_W, PAT_LEN, PAT_LEN) : 0;

    logic [SW-1:0] state;
    logic [SW-1:0] state_nxt;

    // The transition table holds the next state for each current state and
    // each input bit. Every entry is a constant fixed at elaboration time.
    logic [SW-1:0] nxt_on0 [0:PAT_LEN];
    logic [SW-1:0] nxt_on1 [0:PAT_LEN];

    for (genvar gm = 0; gm <= PAT_LEN; gm++) begin : g_tab
        localparam int M_EFF = (gm == PAT_LEN) ? FULL_RESTART : gm;
        localparam logic [SW-1:0] N0 = SW'(kmp_next(PAT_W, PAT_LEN, M_EFF, 1'b0));
        localparam logic [SW-1:0] N1 = SW'(kmp_next(PAT_W, PAT_LEN, M_EFF, 1'b1));
        assign nxt_on0[gm] = N0;
        assign nxt_on1[gm] = N1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_IDLE;
        out       = 1'b0;
        // Codes above S_MATCH cannot be reached. If one ever appears, the
        // detector recovers to idle.
        if (state <= S_MATCH)
            state_nxt = seq_bit ? nxt_on1[state] : nxt_on0[state];
        out = (state == S_MATCH);
    end

endmodule

// File: tb/tb_sequence_detector.sv
// -----------------------------------------------------------------------------
// tb_sequence_detector
// This bench drives two detectors with the same default 1011 pattern: one
// with overlapping detection and one without. Both see the same serial
// stream. The reference model keeps the recent bit history and tests whether
// its tail equals the pattern. In the non-overlapping model, the history is
// emptied after each match.
// -----------------------------------------------------------------------------
module tb_sequence_detector;

    localparam int PLEN = 4;
    localparam logic [PLEN-1:0] PAT = 4'b1011;

    logic clk;
    logic rstn;
    logic seq_bit;
    logic out_ov;
    logic out_no;

    int n_cmp  = 0;
    int n_fail = 0;
    int cnt_ov = 0;
    int cnt_no = 0;
    int pulse_idx[$];
    logic hist_ov[$];
    logic hist_no[$];

    sequence_detector dut_ov (
        .seq_bit (seq_bit),
        .clk     (clk),
        .rstn    (rstn),
        .out     (out_ov)
    );

    sequence_detector #(.OVERLAP(1'b0)) dut_no (
        .seq_bit (seq_bit),
        .clk     (clk),
        .rstn    (rstn),
        .out     (out_no)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_n(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic tail_match(input logic q[$]);
        int n = q.size();
        if (n < PLEN)
            return 1'b0;
        for (int i = 0; i < PLEN; i++)
            if (q[n - PLEN + i] !== PAT[PLEN - 1 - i])
                return 1'b0;
        return 1'b1;
    endfunction

    // Each call starts at a falling edge and ends at the next falling edge.
    task automatic step(input logic b);
        logic exp_ov;
        logic exp_no;
        seq_bit = b;
        hist_ov.push_back(b);
        hist_no.push_back(b);
        @(posedge clk);
        #1;
        exp_ov = tail_match(hist_ov);
        exp_no = tail_match(hist_no);
        if (exp_no)
            hist_no.delete();
        if (hist_ov.size() > 16)
            void'(hist_ov.pop_front());
        check("out_overlap", out_ov, exp_ov);
        check("out_no_overlap", out_no, exp_no);
        if (out_ov) cnt_ov++;
        if (out_no) cnt_no++;
        @(negedge clk);
    endtask

    task automatic feed_bits(input logic [31:0] v, input int n);
        cnt_ov = 0;
        cnt_no = 0;
        pulse_idx.delete();
        for (int i = 0; i < n; i++) begin
            step(v[n - 1 - i]);
            if (out_ov)
                pulse_idx.push_back(i);
        end
    endtask

    // Reset is asserted between clock edges, so the clearing is seen before any edge.
    task automatic do_reset();
        #2;
        rstn    = 1'b0;
        seq_bit = 1'b0;
        #1;
        check("rst_async_ov", out_ov, 1'b0);
        check("rst_async_no", out_no, 1'b0);
        hist_ov.delete();
        hist_no.delete();
        @(posedge clk);
        #1;
        check("rst_edge_ov", out_ov, 1'b0);
        check("rst_edge_no", out_no, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    int first_idx;
    int second_idx;

    initial begin
        rstn    = 1'b0;
        seq_bit = 1'b0;
        #12;
        check("por_ov_12", out_ov, 1'b0);
        check("por_no_12", out_no, 1'b0);
        #10;
        check("por_ov_22", out_ov, 1'b0);
        check("por_no_22", out_no, 1'b0);
        #8;
        rstn = 1'b1;

        // idle zeros after release
        feed_bits(32'b0000, 4);
        check_n("idle_cnt", cnt_ov, 0);

        // basic 0,1,0,1,1
        feed_bits(32'b01011, 5);
        check_n("basic_cnt", cnt_ov, 1);
        first_idx = (pulse_idx.size() > 0) ? pulse_idx[0] : -1;
        check_n("basic_idx", first_idx, 4);

        // long stream: pulses after indices 4 and 24 only
        do_reset();
        feed_bits(32'b0101101001101001001111011100, 28);
        check_n("stream_cnt_ov", cnt_ov, 2);
        check_n("stream_cnt_no", cnt_no, 2);
        first_idx  = (pulse_idx.size() > 0) ? pulse_idx[0] : -1;
        second_idx = (pulse_idx.size() > 1) ? pulse_idx[1] : -1;
        check_n("stream_idx0", first_idx, 4);
        check_n("stream_idx1", second_idx, 24);

        // overlapping matches
        do_reset();
        feed_bits(32'b1011011, 7);
        check_n("ovl_cnt_ov", cnt_ov, 2);
        check_n("ovl_cnt_no", cnt_no, 1);
        second_idx = (pulse_idx.size() > 1) ? pulse_idx[1] : -1;
        check_n("ovl_idx1", second_idx, 6);

        // near misses
        do_reset();
        feed_bits(32'b1111, 4);
        check_n("near_1111", cnt_ov, 0);
        do_reset();
        feed_bits(32'b1010, 4);
        check_n("near_1010", cnt_ov, 0);
        do_reset();
        feed_bits(32'b10011, 5);
        check_n("near_10011", cnt_ov, 0);
        do_reset();
        feed_bits(32'b11011, 5);
        check_n("near_11011", cnt_ov, 1);

        // reset mid-pattern, then a lone 1 must not complete a match
        do_reset();
        feed_bits(32'b101, 3);
        do_reset();
        feed_bits(32'b1, 1);
        check_n("arst_lone1", cnt_ov, 0);
        feed_bits(32'b011, 3);
        check_n("arst_full", cnt_ov, 1);

        // reset while the detect pulse is high
        do_reset();
        feed_bits(32'b1011, 4);
        check("pulse_before_rst", out_ov, 1'b1);
        do_reset();

        // random stream
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
